// File: rtl/kernel_launcher_if.sv
// Bundle of the command, kernel-control and response signals of kernel_launcher.
//
// Handshake rule for both cmd_* and rsp_*: a transfer happens on a rising clk
// edge where valid && ready are both 1; the producer keeps valid and its
// payload stable until that edge, and ready may change freely.
interface kernel_launcher_if #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 1,
  parameter int RES_W  = 2
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_init;
  logic [DEPTH*DATA_W-1:0] cmd_arr;

  logic                    k_r_enable;
  logic                    k_init_i;
  logic                    k_controlArr;
  logic                    k_controlArrWEnable_a;
  logic [ADDR_W-1:0]       k_controlArrAddr_a;
  logic [DATA_W-1:0]       k_controlArrWData_a;
  logic [DATA_W-1:0]       k_controlArrRData_a;
  logic                    k_w_enable;
  logic [RES_W-1:0]        k_result;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [RES_W-1:0]        rsp_result;
  logic [DEPTH*DATA_W-1:0] rsp_arr;
  logic                    rsp_timeout;

  // launcher side
  modport master (
    input  cmd_valid, cmd_init, cmd_arr,
    input  k_controlArrRData_a, k_w_enable, k_result,
    input  rsp_ready,
    output cmd_ready,
    output k_r_enable, k_init_i, k_controlArr, k_controlArrWEnable_a,
    output k_controlArrAddr_a, k_controlArrWData_a,
    output rsp_valid, rsp_result, rsp_arr, rsp_timeout
  );

  // host / kernel side
  modport slave (
    output cmd_valid, cmd_init, cmd_arr,
    output k_controlArrRData_a, k_w_enable, k_result,
    output rsp_ready,
    input  cmd_ready,
    input  k_r_enable, k_init_i, k_controlArr, k_controlArrWEnable_a,
    input  k_controlArrAddr_a, k_controlArrWData_a,
    input  rsp_valid, rsp_result, rsp_arr, rsp_timeout
  );
endinterface

// File: rtl/kernel_launcher.sv
// Command/response wrapper around the `main` kernel: preloads its array,
// pulses start, waits for done (with timeout), reads the array back and
// returns result + image on the response channel.
module kernel_launcher #(
  parameter int ADDR_W  = 1,
  parameter int DATA_W  = 1,
  parameter int RES_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  kernel_launcher_if.master bus,
  output logic [2:0]        dbg_state
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int ARR_W = DEPTH * DATA_W;
  localparam int TW    = $clog2(TIMEOUT + 1);

  // timer value seen during the final permitted RUN cycle
  localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   T_MAX    = TW'(TIMEOUT);
  localparam logic [ADDR_W:0] IDX_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] IDX_END  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DUMP  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q;     // one extra bit: DUMP counts to DEPTH
  logic [TW-1:0]     timer_q;
  logic              init_q;
  logic [ARR_W-1:0]  arr_q;
  logic [RES_W-1:0]  res_q;
  logic [ARR_W-1:0]  rsp_arr_q;
  logic              to_q;

  logic [ADDR_W-1:0] idx_a;
  logic [ADDR_W-1:0] cap_a;     // entry captured in DUMP lags the address by one

  logic              cmd_ready_c, r_enable_c, ctrl_c, wen_c, rsp_valid_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  assign idx_a = idx_q[ADDR_W-1:0];
  assign cap_a = idx_a - 1'b1;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state decode and kernel/host-facing strobes
  always_comb begin
    state_d     = state_q;
    cmd_ready_c = 1'b0;
    r_enable_c  = 1'b0;
    ctrl_c      = 1'b0;
    wen_c       = 1'b0;
    addr_c      = '0;
    wdata_c     = '0;
    rsp_valid_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        ctrl_c  = 1'b1;
        wen_c   = 1'b1;
        addr_c  = idx_a;
        wdata_c = arr_q[int'(idx_a) * DATA_W +: DATA_W];
        if (idx_q == IDX_LAST) state_d = S_START;
      end
      S_START: begin
        // done is stale here, so it is deliberately not examined
        r_enable_c = 1'b1;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (bus.k_w_enable)       state_d = S_DUMP;
        else if (timer_q >= T_LAST) state_d = S_RESP;
      end
      S_DUMP: begin
        ctrl_c = 1'b1;
        if (idx_q != IDX_END) addr_c  = idx_a;
        else                  state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // command latch, index/timer counters and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      timer_q   <= '0;
      init_q    <= 1'b0;
      arr_q     <= '0;
      res_q     <= '0;
      rsp_arr_q <= '0;
      to_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            init_q  <= bus.cmd_init;
            arr_q   <= bus.cmd_arr;
            idx_q   <= '0;
            timer_q <= '0;
          end
        end
        S_LOAD: begin
          idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        S_RUN: begin
          timer_q <= (timer_q == T_MAX) ? T_MAX : timer_q + 1'b1;
          if (bus.k_w_enable) begin
            res_q <= bus.k_result;
            to_q  <= 1'b0;
          end else if (timer_q >= T_LAST) begin
            // kernel may still be running: leave its array alone
            res_q     <= '0;
            rsp_arr_q <= '0;
            to_q      <= 1'b1;
          end
        end
        S_DUMP: begin
          if (idx_q != '0)
            rsp_arr_q[int'(cap_a) * DATA_W +: DATA_W] <= bus.k_controlArrRData_a;
          if (idx_q != IDX_END) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready             = cmd_ready_c;
  assign bus.k_r_enable            = r_enable_c;
  assign bus.k_init_i              = init_q;
  assign bus.k_controlArr          = ctrl_c;
  assign bus.k_controlArrWEnable_a = wen_c;
  assign bus.k_controlArrAddr_a    = addr_c;
  assign bus.k_controlArrWData_a   = wdata_c;
  assign bus.rsp_valid             = rsp_valid_c;
  assign bus.rsp_result            = res_q;
  assign bus.rsp_arr               = rsp_arr_q;
  assign bus.rsp_timeout           = to_q;
  assign dbg_state                 = state_q;
endmodule

// File: tb/tb_kernel_launcher.sv
// Bench for kernel_launcher: kernel stub, command driver, response consumer,
// and a monitor that checks each response against a queued expectation.
module tb_kernel_launcher;
  localparam int ADDR_W  = 1;
  localparam int DATA_W  = 1;
  localparam int RES_W   = 2;
  localparam int TIMEOUT = 4;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int ARR_W   = DEPTH * DATA_W;
  localparam int EXP_W   = 1 + RES_W + ARR_W + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kernel_launcher_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();
  logic [2:0] dbg_state;

  kernel_launcher #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- kernel stub ----------------
  // Start: latch init, finish after stub_lat+1 cycles (or never when hanging).
  // Finish: result = 2 + init; with init = 0, entry 0 is cleared.
  // Done stays high until the next start pulse.
  int   stub_lat  = 0;
  bit   stub_hang = 1'b0;
  logic [DATA_W-1:0] mem [DEPTH];
  logic st_done = 1'b0;
  logic [RES_W-1:0] st_res = '0;
  logic [DATA_W-1:0] st_rdata = '0;
  logic st_busy = 1'b0, st_hang = 1'b0, st_init = 1'b0;
  int   st_cnt = 0;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (bus.k_controlArr && bus.k_controlArrWEnable_a)
      mem[bus.k_controlArrAddr_a] <= bus.k_controlArrWData_a;
    st_rdata <= mem[bus.k_controlArrAddr_a];
    if (bus.k_r_enable) begin
      st_busy <= 1'b1;
      st_hang <= stub_hang;
      st_cnt  <= stub_lat;
      st_init <= bus.k_init_i;
      st_done <= 1'b0;
    end else if (st_busy && !st_hang) begin
      if (st_cnt == 0) begin
        st_done <= 1'b1;
        st_res  <= RES_W'(2 + int'(st_init));
        st_busy <= 1'b0;
        if (!st_init) mem[0] <= '0;
      end else begin
        st_cnt <= st_cnt - 1;
      end
    end
  end

  assign bus.k_w_enable          = st_done;
  assign bus.k_result            = st_res;
  assign bus.k_controlArrRData_a = st_rdata;

  // ---------------- reference model ----------------
  function automatic logic [EXP_W-1:0] model(input logic init, input logic [ARR_W-1:0] arr,
                                             input int lat, input bit hang);
    logic [ARR_W-1:0] a;
    if (hang)
      return {1'b1, {RES_W{1'b0}}, {ARR_W{1'b0}}, 8'(DEPTH), 8'd1, 8'd0, 8'(TIMEOUT + 1)};
    a = arr;
    if (!init) a[DATA_W-1:0] = '0;
    // start -> (lat+2) RUN cycles -> DEPTH+1 DUMP cycles -> RESP
    return {1'b0, RES_W'(2 + int'(init)), a, 8'(DEPTH), 8'd1, 8'(DEPTH + 1), 8'(lat + DEPTH + 4)};
  endfunction

  // ---------------- response consumer ----------------
  int stall_next = 0;
  int stall_cnt  = 0;
  bit seen_valid = 1'b0;
  initial bus.rsp_ready = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      bus.rsp_ready = 1'b0;
      seen_valid = 1'b0;
      stall_cnt = 0;
    end else if (bus.rsp_valid) begin
      if (!seen_valid) begin
        seen_valid = 1'b1;
        stall_cnt  = stall_next;
        stall_next = 0;
      end
      if (stall_cnt > 0) begin
        bus.rsp_ready = 1'b0;
        stall_cnt--;
      end else begin
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end else begin
      seen_valid = 1'b0;
      bus.rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0, start_cyc = 0, lat_meas = 0;
  int n_wr = 0, n_st = 0, n_rd = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [RES_W-1:0] held_res;
  logic [ARR_W-1:0] held_arr;
  logic held_to;

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    cyc++;
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        n_wr = 0; n_st = 0; n_rd = 0;
      end
      if (bus.k_controlArr && bus.k_controlArrWEnable_a) n_wr++;
      if (bus.k_controlArr && !bus.k_controlArrWEnable_a) n_rd++;
      if (bus.k_r_enable) begin
        n_st++;
        start_cyc = cyc;
      end
      if (prev_valid && !prev_ready) begin
        check("rsp_valid_held", 64'(bus.rsp_valid), 64'(1));
        check("rsp_result_held", 64'(bus.rsp_result), 64'(held_res));
        check("rsp_arr_held", 64'(bus.rsp_arr), 64'(held_arr));
        check("rsp_timeout_held", 64'(bus.rsp_timeout), 64'(held_to));
      end
      if (bus.rsp_valid) begin
        check("cmd_ready_during_resp", 64'(bus.cmd_ready), 64'(0));
        if (!prev_valid) lat_meas = cyc - start_cyc;
        held_res = bus.rsp_result;
        held_arr = bus.rsp_arr;
        held_to  = bus.rsp_timeout;
        if (bus.rsp_ready) begin
          check("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_timeout", 64'(bus.rsp_timeout), 64'(e[EXP_W-1]));
            check("rsp_result", 64'(bus.rsp_result), 64'(e[EXP_W-2 -: RES_W]));
            check("rsp_arr", 64'(bus.rsp_arr), 64'(e[32 +: ARR_W]));
            check("load_writes", 64'(n_wr), 64'(e[24 +: 8]));
            check("start_pulses", 64'(n_st), 64'(e[16 +: 8]));
            check("dump_reads", 64'(n_rd), 64'(e[8 +: 8]));
            check("start_to_rsp_cycles", 64'(lat_meas), 64'(e[0 +: 8]));
          end
        end
      end
      prev_valid = bus.rsp_valid;
      prev_ready = bus.rsp_ready;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_cmd_ready(output bit ok);
    int waited = 0;
    @(negedge clk);
    while (!bus.cmd_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    ok = bus.cmd_ready;
    if (!ok) check("cmd_ready_wait", 64'(bus.cmd_ready), 64'(1));
  endtask

  task automatic send_cmd(input logic init, input logic [ARR_W-1:0] arr,
                          input int lat, input bit hang, input int stall);
    bit ok;
    wait_cmd_ready(ok);
    if (!ok) return;
    stub_lat   = lat;
    stub_hang  = hang;
    stall_next = stall;
    bus.cmd_valid = 1'b1;
    bus.cmd_init  = init;
    bus.cmd_arr   = arr;
    exp_q.push_back(model(init, arr, lat, hang));
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_init  = 1'($urandom_range(0, 1));
    bus.cmd_arr   = ARR_W'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
    check({tag, "_ctrl"}, 64'({bus.k_controlArr, bus.k_controlArrWEnable_a,
                               bus.k_r_enable, bus.k_init_i}), 64'(0));
    check({tag, "_addr_wdata"}, 64'({bus.k_controlArrAddr_a, bus.k_controlArrWData_a}), 64'(0));
    check({tag, "_rsp"}, 64'({bus.rsp_valid, bus.rsp_timeout, bus.rsp_result, bus.rsp_arr}), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int waited;
    bus.cmd_valid = 1'b0;
    bus.cmd_init  = 1'b0;
    bus.cmd_arr   = '0;

    #3;
    check_idle_outputs("reset");
    check("reset_state", 64'(dbg_state), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    send_cmd(1'b0, 2'b11, 1, 1'b0, 0);   // result 2, arr 10
    send_cmd(1'b1, 2'b01, 0, 1'b0, 0);   // result 3, arr 01
    send_cmd(1'b1, 2'b11, 0, 1'b1, 0);   // kernel hangs -> timeout
    send_cmd(1'b1, 2'b10, 2, 1'b0, 10);  // done in last RUN cycle, consumer stalls 10
    send_cmd(1'b0, 2'b01, 0, 1'b0, 0);   // result 2

    // reset while LOAD is presenting index 1
    wait_cmd_ready(ok);
    if (ok) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_init  = 1'b1;
      bus.cmd_arr   = 2'b11;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      check("midload_addr", 64'(bus.k_controlArrAddr_a), 64'(1));
      check("midload_wen", 64'(bus.k_controlArrWEnable_a), 64'(1));
      rst = 1'b1;
      #1;
      check_idle_outputs("midload_reset");
      @(negedge clk);
      rst = 1'b0;
    end
    send_cmd(1'b0, 2'b11, 0, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      send_cmd(1'($urandom_range(0, 1)), ARR_W'($urandom),
               $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
               $urandom_range(0, 3));
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("drain_outstanding", 64'(exp_q.size()), 64'(0));
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/kernel_launcher.md
Name: kernel_launcher

Overview:
- Host-side sequencer that sits directly upstream and downstream of the synthesized `main` kernel.
- Accepts one command, preloads the kernel's array through its control port, pulses `r_enable` with `init_i`, and waits for `w_enable`.
- After completion it captures `result`, reads the array back, and returns everything on a valid/ready response channel.
- Turns the kernel's raw start/done protocol into a clean command/response transaction with a timeout.

Parameters:
- ADDR_W, 1, array address width; DEPTH = 2**ADDR_W entries.
- DATA_W, 1, array word width.
- RES_W, 2, kernel result width.
- TIMEOUT, 255, maximum cycles in RUN before aborting; TIMEOUT >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  launcher can accept a command
- cmd_init  in  1  value driven on kernel init_i
- cmd_arr  in  DEPTH*DATA_W  preload image; entry i = bits [i*DATA_W +: DATA_W]
- k_r_enable  out  1  kernel start pulse
- k_init_i  out  1  kernel init value
- k_controlArr  out  1  host owns the kernel array
- k_controlArrWEnable_a  out  1  array write enable
- k_controlArrAddr_a  out  ADDR_W  array address
- k_controlArrWData_a  out  DATA_W  array write data
- k_controlArrRData_a  in  DATA_W  array read data; valid 1 cycle after address with WEnable=0
- k_w_enable  in  1  kernel done flag
- k_result  in  RES_W  kernel result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  RES_W  captured result
- rsp_arr  out  DEPTH*DATA_W  array readback image
- rsp_timeout  out  1  run aborted by timeout

Behaviour:
- Reset (async, immediate):
  - state = IDLE; all registers and outputs are 0.
  - cmd_ready = 1, because it is decoded from IDLE.
- FSM states: IDLE → LOAD → START → RUN → DUMP → RESP → IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch cmd_init and cmd_arr, clear the index and timer, and go to LOAD.
- LOAD (DEPTH cycles):
  - Drive k_controlArr = 1, WEnable = 1, Addr = idx, WData = latched entry idx.
  - idx increments each cycle; after idx = DEPTH-1, go to START.
- START (1 cycle):
  - k_controlArr = 0, k_r_enable = 1, k_init_i = latched init.
  - k_w_enable is ignored in this cycle, because it holds a stale value from the previous run or is undefined before the first run.
  - Go to RUN.
- RUN:
  - k_controlArr = 0, k_r_enable = 0; k_init_i is held.
  - The timer increments every cycle.
  - If k_w_enable = 1: capture k_result into rsp_result, set rsp_timeout = 0, go to DUMP.
  - Else if the timer reaches TIMEOUT: set rsp_timeout = 1, rsp_result = 0, rsp_arr = 0, go to RESP.
  - The kernel array must not be touched after a timeout, because controlArr would override the still-running kernel.
- DUMP (DEPTH+1 cycles):
  - k_controlArr = 1, WEnable = 0.
  - Address i is presented in cycle i.
  - k_controlArrRData_a is sampled in cycle i+1 into rsp_arr entry i, so the read pipeline has a 1-cycle lag.
  - After the last capture, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_result, rsp_arr and rsp_timeout are stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE; the response outputs hold their values until the next capture.
- k_controlArr is 0 in every state except LOAD and DUMP.
- k_controlArrWEnable_a is 1 only in LOAD.
- Address and WData are 0 when not in use.
- Back-to-back commands:
  - The earliest acceptance of the next command is the cycle after the RESP handshake.
  - cmd_ready is 0 in every other state.
- rst asserted mid-run:
  - The launcher returns to IDLE at once, and any in-flight response is lost.
  - The kernel is left as is; the next START pulse re-initializes it.
- Width rules: the timer is $clog2(TIMEOUT+1) bits wide and saturates at TIMEOUT.

Test Plan:
- Reset mid-LOAD (assert rst during idx=1) → all outputs 0, cmd_ready = 1 immediately; a subsequent command completes normally.
- cmd_init = 0, cmd_arr = 2'b11 → exactly 2 LOAD writes and 1 START pulse; rsp_result = 2, rsp_arr = 2'b10 (entry 0 overwritten with 0), rsp_timeout = 0.
- cmd_init = 1, cmd_arr = 2'b01 → rsp_result = 3, rsp_arr = 2'b01 (array untouched), rsp_timeout = 0.
- Kernel stub that never raises k_w_enable, TIMEOUT = 4 → rsp_valid rises 5 cycles after START; rsp_timeout = 1, rsp_result = 0, rsp_arr = 0, and no DUMP accesses occur.
- Stale done (k_w_enable held 1 from a prior run while in START) → not accepted as completion; capture occurs only once it is seen high in RUN.
- rsp_ready held low for 10 cycles → response fields stable and cmd_ready = 0 throughout; rsp_ready = 1 returns to IDLE; a second command with cmd_init = 0 yields rsp_result = 2.
